// File: rtl/lcd_bus_pkg.sv
// Shared constants for the LCD 8080-style bus writer: word layout, FSM encoding
// and delay-command marker. The delay feature is enabled with LCD_DELAY_CMD_EN.
package lcd_bus_pkg;

  localparam int WORD_W = 17;

  localparam logic ID_CMD  = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [7:0] DLY_MARK = 8'hFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_WR_LO = 3'd2;
  localparam logic [2:0] ST_WR_HI = 3'd3;
  localparam logic [2:0] ST_DELAY = 3'd4;

  // A command word whose high payload byte is the marker carries a wait count.
  function automatic logic is_dly_word(input logic [WORD_W-1:0] w);
    return (w[WORD_W-1] == ID_CMD) && (w[15:8] == DLY_MARK);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Wait timer for in-stream delay commands: a DELAY_UNIT prescaler feeding an
// 8-bit tick down-counter. Only instantiated when LCD_DELAY_CMD_EN is defined.
module lcd_delay_timer #(
  parameter int DELAY_UNIT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] ticks_i,
  output logic       done_o
);

  localparam int PW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DELAY_UNIT - 1);

  logic          active_q, active_d;
  logic [7:0]    tick_q, tick_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;

  assign pre_wrap = (pre_q == PRE_LAST);

  // done is high during the last waiting cycle; a zero count waits one cycle.
  assign done_o = active_q && ((tick_q == 8'd0) || ((tick_q == 8'd1) && pre_wrap));

  always_comb begin
    active_d = active_q;
    tick_d   = tick_q;
    pre_d    = pre_q;
    if (start_i) begin
      active_d = 1'b1;
      tick_d   = ticks_i;
      pre_d    = '0;
    end else if (active_q) begin
      if (done_o) begin
        active_d = 1'b0;
      end else if (pre_wrap) begin
        pre_d  = '0;
        tick_d = tick_q - 8'd1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      tick_q   <= 8'd0;
      pre_q    <= '0;
    end else begin
      active_q <= active_d;
      tick_q   <= tick_d;
      pre_q    <= pre_d;
    end
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// LCD output stage: pops {ID,DATA} words from a show-ahead FIFO and drives one
// 8080 write cycle per word. Define LCD_DELAY_CMD_EN to honour in-stream delay words.
module lcd_bus_writer
  import lcd_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int WR_LO_CYC  = 2,
  parameter int WR_HI_CYC  = 2,
  parameter int DELAY_UNIT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rempty,
  input  logic [WORD_W-1:0] rdata,
  output logic              rinc,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [15:0]       lcd_data,
  output logic              busy
);

  if ((SETUP_CYC < 1) || (SETUP_CYC > 255) || (WR_LO_CYC < 1) || (WR_LO_CYC > 255) ||
      (WR_HI_CYC < 1) || (WR_HI_CYC > 255) || (DELAY_UNIT < 1)) begin : g_bad_param
    $error("lcd_bus_writer: timing parameter out of range");
  end

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] WR_LO_LAST = 8'(WR_LO_CYC - 1);
  localparam logic [7:0] WR_HI_LAST = 8'(WR_HI_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rinc_q, rinc_d;
  logic        cs_n_q, cs_n_d;
  logic        rs_q, rs_d;
  logic        wr_n_q, wr_n_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        pop;
  logic        take_dly;

  // FIFO handshake: !rempty means rdata holds a valid head word; a pop is decided
  // in the cycle that sees it valid, and rinc pulses for exactly the following cycle.
`ifdef LCD_DELAY_CMD_EN
  logic dly_done;

  assign take_dly = is_dly_word(rdata);

  lcd_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (pop && take_dly),
    .ticks_i (rdata[7:0]),
    .done_o  (dly_done)
  );
`else
  assign take_dly = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    rinc_d  = 1'b0;
    cs_n_d  = cs_n_q;
    rs_d    = rs_q;
    wr_n_d  = wr_n_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        pop   = !rempty;
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          wr_n_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (cnt_q == WR_LO_LAST) begin
          wr_n_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        // Last hold cycle: chain straight into the next word to keep CS# low.
        if (cnt_q == WR_HI_LAST) begin
          if (!rempty) begin
            pop = 1'b1;
          end else begin
            cs_n_d  = 1'b1;
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef LCD_DELAY_CMD_EN
      ST_DELAY: begin
        cnt_d = 8'd0;
        if (dly_done) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      rinc_d = 1'b1;
      cnt_d  = 8'd0;
      if (take_dly) begin
        // Delay words never reach the pins; the bus is released while waiting.
        cs_n_d  = 1'b1;
        state_d = ST_DELAY;
      end else begin
        rs_d    = rdata[WORD_W-1];
        data_d  = rdata[15:0];
        cs_n_d  = 1'b0;
        state_d = ST_SETUP;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rinc_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      data_q  <= 16'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rinc_q  <= rinc_d;
      cs_n_q  <= cs_n_d;
      rs_q    <= rs_d;
      wr_n_q  <= wr_n_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign rinc     = rinc_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_rs   = rs_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_rd_n = 1'b1;
  assign lcd_data = data_q;
  assign busy     = busy_q;

endmodule
